pipeline_control_unit: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
- Arbitrates four stall/flush sources into one per-stage set of hold, bubble and flush controls:
  - icache miss stall
  - dcache miss stall
  - load-use hazard on the ID instruction
  - jump/branch redirect from EX
- Guarantees a load-use hazard costs exactly one bubble.
- Guarantees a redirect that arrives during a cache stall is never lost.

---
 rtl/pipeline_control_unit.sv | 128 ++++++++++++
 tb/tb_pipeline_control_unit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/pipeline_control_unit.sv
// Stall/flush sequencer for the 5-stage pipeline: merges cache stalls, load-use and EX redirects into per-stage controls.
// Optional event counters are built when PIPECTRL_PERF_EN is defined.
module pipeline_control_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_stall_from_icache,
    input  logic                      in_stall_from_dcache,
    input  logic                      inMemReadEx,
    input  logic [REG_ADDR_WIDTH-1:0] inDestRegisterEx,
    input  logic [31:0]               inIns,
    input  logic                      inFlushFromJump,
    output logic                      outStallIF,
    output logic                      outStallID,
    output logic                      outBubbleEX,
    output logic                      outStallMEM,
    output logic                      outBubbleWB,
    output logic                      outFlush,
    output logic [1:0]                debug_state
`ifdef PIPECTRL_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]     outPerfLoadUse,
    output logic [PERF_WIDTH-1:0]     outPerfIcache,
    output logic [PERF_WIDTH-1:0]     outPerfDcache,
    output logic [PERF_WIDTH-1:0]     outPerfFlush
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LU_BUBBLE  = 2'd1,
        FLUSH_PEND = 2'd2
    } state_t;

    state_t state, state_next;

    logic [REG_ADDR_WIDTH-1:0] rs1, rs2;
    logic [6:0] opcode;
    logic uses_rs2, detect, cache_stall, flush_now, lu_bubble;
    logic unused_ins;

    assign rs1        = REG_ADDR_WIDTH'(inIns[19:15]);
    assign rs2        = REG_ADDR_WIDTH'(inIns[24:20]);
    assign opcode     = inIns[6:0];
    assign unused_ins = ^{inIns[31:25], inIns[14:7]};

    // Only R-type, R-type-W, store and branch formats actually read rs2.
    assign uses_rs2 = (opcode == 7'b0110011) || (opcode == 7'b0111011) ||
                      (opcode == 7'b0100011) || (opcode == 7'b1100011);

    assign detect = inMemReadEx && (inDestRegisterEx != '0) &&
                    ((inDestRegisterEx == rs1) || (uses_rs2 && (inDestRegisterEx == rs2)));

    assign cache_stall = in_stall_from_icache || in_stall_from_dcache;
    assign flush_now   = !cache_stall && (inFlushFromJump || (state == FLUSH_PEND));
    assign lu_bubble   = reset_n && !cache_stall && !flush_now && (state == RUN) && detect;
    assign debug_state = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (inFlushFromJump && cache_stall) begin
            state_next = FLUSH_PEND;
        end else if (in_stall_from_dcache || in_stall_from_icache) begin
            state_next = state;
        end else if (flush_now) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:       state_next = detect ? LU_BUBBLE : RUN;
                LU_BUBBLE: state_next = RUN;
                default:   state_next = RUN;
            endcase
        end
    end

    always_comb begin
        outStallIF  = 1'b0;
        outStallID  = 1'b0;
        outBubbleEX = 1'b0;
        outStallMEM = 1'b0;
        outBubbleWB = 1'b0;
        outFlush    = 1'b0;
        if (!reset_n) begin
            outFlush = 1'b0;
        end else if (in_stall_from_dcache) begin
            outStallIF  = 1'b1;
            outStallID  = 1'b1;
            outStallMEM = 1'b1;
            outBubbleWB = 1'b1;
        end else if (flush_now) begin
            outFlush    = 1'b1;
            outBubbleEX = 1'b1;
        end else if (in_stall_from_icache) begin
            outStallIF = 1'b1;
        end else if (lu_bubble) begin
            outStallIF  = 1'b1;
            outStallID  = 1'b1;
            outBubbleEX = 1'b1;
        end
    end

`ifdef PIPECTRL_PERF_EN
    // Saturating counters; hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outPerfLoadUse <= '0;
            outPerfIcache  <= '0;
            outPerfDcache  <= '0;
            outPerfFlush   <= '0;
        end else begin
            if (lu_bubble && !(&outPerfLoadUse))            outPerfLoadUse <= outPerfLoadUse + 1'b1;
            if (in_stall_from_icache && !(&outPerfIcache))  outPerfIcache  <= outPerfIcache + 1'b1;
            if (in_stall_from_dcache && !(&outPerfDcache))  outPerfDcache  <= outPerfDcache + 1'b1;
            if (outFlush && !(&outPerfFlush))               outPerfFlush   <= outPerfFlush + 1'b1;
        end
    end
`else
    localparam int unused_perf_width = PERF_WIDTH;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Randomized bench for pipeline_control_unit against a flag-based reference model of the stall/flush rules.
// Perf counters are checked only when PIPECTRL_PERF_EN is defined.
module tb_pipeline_control_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        ic, dc, ld, jmp;
    logic [4:0]  rd;
    logic [31:0] ins;
    logic        o_sif, o_sid, o_bex, o_smem, o_bwb, o_fl;
    logic [1:0]  dbg_state;
`ifdef PIPECTRL_PERF_EN
    logic [31:0] p_lu, p_ic, p_dc, p_fl;
`endif

    always #5 clk = ~clk;

    pipeline_control_unit dut (
        .clk(clk), .reset_n(reset_n),
        .in_stall_from_icache(ic), .in_stall_from_dcache(dc),
        .inMemReadEx(ld), .inDestRegisterEx(rd), .inIns(ins), .inFlushFromJump(jmp),
        .outStallIF(o_sif), .outStallID(o_sid), .outBubbleEX(o_bex),
        .outStallMEM(o_smem), .outBubbleWB(o_bwb), .outFlush(o_fl),
        .debug_state(dbg_state)
`ifdef PIPECTRL_PERF_EN
        , .outPerfLoadUse(p_lu), .outPerfIcache(p_ic), .outPerfDcache(p_dc), .outPerfFlush(p_fl)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a pending-redirect flag and a "bubble already paid" flag.
    logic        pend_m = 1'b0;
    logic        paid_m = 1'b0;
    int unsigned lu_m = 0, ic_m = 0, dc_m = 0, fl_m = 0;

    logic [6:0] op_tbl [7] = '{7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011,
                               7'b0010011, 7'b0000011, 7'b1101111};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_detect(input logic l, input logic [4:0] d, input logic [31:0] i);
        logic reads_rs2;
        reads_rs2 = (i[6:0] == 7'b0110011) || (i[6:0] == 7'b0111011) ||
                    (i[6:0] == 7'b0100011) || (i[6:0] == 7'b1100011);
        return l && (d != 0) && ((d == i[19:15]) || (reads_rs2 && d == i[24:20]));
    endfunction

    // Apply one cycle of inputs, compare outputs, then advance the model.
    task automatic step(input string tag, input logic r, input logic i_s, input logic d_s,
                        input logic l, input logic [4:0] d, input logic [31:0] i, input logic j);
        logic [5:0] e;
        logic       fl, lu;
        @(negedge clk);
        reset_n = r; ic = i_s; dc = d_s; ld = l; rd = d; ins = i; jmp = j;
        #2;
        e = 6'b0; fl = 1'b0; lu = 1'b0;
        if (!r) begin
            pend_m = 1'b0; paid_m = 1'b0;
            lu_m = 0; ic_m = 0; dc_m = 0; fl_m = 0;
        end else begin
            if (d_s)                            e = 6'b110110;
            else if (!i_s && (j || pend_m))     begin e = 6'b001001; fl = 1'b1; end
            else if (i_s)                       e = 6'b100000;
            else if (model_detect(l, d, i) && !paid_m) begin e = 6'b111000; lu = 1'b1; end
            lu_m += 32'(lu); ic_m += 32'(i_s); dc_m += 32'(d_s); fl_m += 32'(fl);
            if (j && (i_s || d_s))  begin pend_m = 1'b1; paid_m = 1'b0; end
            else if (fl)            begin pend_m = 1'b0; paid_m = 1'b0; end
            else if (!i_s && !d_s)  paid_m = lu;
        end
        check_val(tag, {26'b0, o_sif, o_sid, o_bex, o_smem, o_bwb, o_fl}, {26'b0, e});
    endtask

    task automatic check_perf(input string tag);
`ifdef PIPECTRL_PERF_EN
        check_val({tag, "_lu"}, p_lu, lu_m);
        check_val({tag, "_ic"}, p_ic, ic_m);
        check_val({tag, "_dc"}, p_dc, dc_m);
        check_val({tag, "_fl"}, p_fl, fl_m);
`else
        checks = checks + 0;
        if (tag.len() == 0) $display("empty perf tag");
`endif
    endtask

    localparam logic [31:0] ADD_X6_X5_X7  = {7'b0, 5'd7, 5'd5, 3'b0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_X6_X0_X0  = {7'b0, 5'd0, 5'd0, 3'b0, 5'd6, 7'b0110011};
    localparam logic [31:0] ADDI_X6_X1_R5 = {7'b0, 5'd5, 5'd1, 3'b0, 5'd6, 7'b0010011};

    initial begin
        reset_n = 1'b0; ic = 0; dc = 0; ld = 0; rd = 0; ins = 0; jmp = 0;
        // Reset with every input active: outputs must stay low.
        step("rst_all_in", 1'b0, 1'b1, 1'b1, 1'b1, 5'd5, ADD_X6_X5_X7, 1'b1);
        step("rst_idle",   1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0);
        check_perf("rst_perf");

        // Load-use costs one bubble.
        step("lu_c0", 1'b1, 0, 0, 1, 5'd5, ADD_X6_X5_X7, 0);
        step("lu_c1", 1'b1, 0, 0, 1, 5'd5, ADD_X6_X5_X7, 0);
        step("lu_c2", 1'b1, 0, 0, 0, 5'd0, 32'h0, 0);
        // x0 destination and I-type rs2 field never stall.
        step("lu_x0",   1'b1, 0, 0, 1, 5'd0, ADD_X6_X0_X0, 0);
        step("lu_itype", 1'b1, 0, 0, 1, 5'd5, ADDI_X6_X1_R5, 0);
        // Redirect during a 3-cycle dcache stall is deferred.
        step("dfl_c0", 1'b1, 0, 1, 0, 5'd0, 32'h0, 1);
        step("dfl_c1", 1'b1, 0, 1, 0, 5'd0, 32'h0, 0);
        step("dfl_c2", 1'b1, 0, 1, 0, 5'd0, 32'h0, 0);
        step("dfl_c3", 1'b1, 0, 0, 0, 5'd0, 32'h0, 0);
        step("dfl_c4", 1'b1, 0, 0, 0, 5'd0, 32'h0, 0);
        // Jump together with load-use: flush wins, then detect re-evaluated.
        step("jlu_c0", 1'b1, 0, 0, 1, 5'd5, ADD_X6_X5_X7, 1);
        step("jlu_c1", 1'b1, 0, 0, 1, 5'd5, ADD_X6_X5_X7, 0);
        step("jlu_c2", 1'b1, 0, 0, 0, 5'd0, 32'h0, 0);
        // icache stall over a load: IF stall only.
        for (int k = 0; k < 4; k++) step("ic_lu", 1'b1, 1, 0, 1, 5'd5, ADD_X6_X5_X7, 0);
        step("ic_both", 1'b1, 1, 1, 0, 5'd0, 32'h0, 0);
        check_perf("plan_perf");
        // Reset while a redirect is pending discards it.
        step("rp_c0", 1'b1, 0, 1, 0, 5'd0, 32'h0, 1);
        step("rp_c1", 1'b0, 0, 1, 0, 5'd0, 32'h0, 0);
        step("rp_c2", 1'b1, 0, 0, 0, 5'd0, 32'h0, 0);
        check_perf("rp_perf");

        for (int n = 0; n < 3000; n++) begin
            logic [31:0] r_ins;
            r_ins = $urandom;
            r_ins[6:0]   = op_tbl[$urandom_range(0, 6)];
            r_ins[19:15] = 5'($urandom_range(0, 3));
            r_ins[24:20] = 5'($urandom_range(0, 3));
            step("rand", ($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 1) == 0), 5'($urandom_range(0, 3)), r_ins,
                 ($urandom_range(0, 7) == 0));
        end
        check_perf("rand_perf");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
